// File: rtl/leading_bit_normalizer.sv
// Iterative leading/trailing-one normalizer.
// Finds the shift amount that moves the leading '1' to the MSB (mode=0, CLZ) or
// the trailing '1' to the LSB (mode=1, CTZ), and returns the normalized value.
// One bit is tested per cycle; start/done handshake, results held until the next op.
module leading_bit_normalizer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             md_q, md_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             zero_q, zero_d;
    logic             test_bit;

    assign test_bit = md_q ? work_q[0] : work_q[WIDTH-1];

    // Next-state: accept in idle, test/shift one bit per cycle, single-cycle done.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        md_d    = md_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        count_d = count_q;
        zero_d  = zero_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    work_d  = a;
                    md_d    = mode;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                // An all-zero work value can only come from a zero operand: a nonzero
                // operand always hits its set bit before it could be shifted out.
                // Routing it through here gives it the same one-cycle latency as count=0.
                if (work_q == '0) begin
                    r_d     = '0;
                    count_d = CNT_W'(WIDTH);
                    zero_d  = 1'b1;
                    state_d = StDone;
                end else if (test_bit) begin
                    r_d     = work_q;
                    count_d = cnt_q;
                    zero_d  = 1'b0;
                    state_d = StDone;
                end else begin
                    work_d = md_q ? (work_q >> 1) : (work_q << 1);
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and result registers; reset aborts any operation immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            work_q  <= '0;
            md_q    <= 1'b0;
            cnt_q   <= '0;
            r_q     <= '0;
            count_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            md_q    <= md_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            count_q <= count_d;
            zero_q  <= zero_d;
        end
    end

    // Outputs decoded directly from registered state.
    always_comb begin
        busy  = (state_q != StIdle);
        done  = (state_q == StDone);
        r     = r_q;
        count = count_q;
        zero  = zero_q;
    end

endmodule

// File: tb/tb_leading_bit_normalizer.sv
// Directed + random bench for leading_bit_normalizer.
module tb_leading_bit_normalizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic        mode;
    logic        busy;
    logic        done;
    logic [31:0] r;
    logic [5:0]  count;
    logic        zero;

    int nerr = 0;
    int nchk = 0;

    leading_bit_normalizer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .mode  (mode),
        .busy  (busy),
        .done  (done),
        .r     (r),
        .count (count),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ref_clz(input logic [31:0] v);
        for (int i = 31; i >= 0; i--) if (v[i]) return 31 - i;
        return 32;
    endfunction

    function automatic int ref_ctz(input logic [31:0] v);
        for (int i = 0; i < 32; i++) if (v[i]) return i;
        return 32;
    endfunction

    // Launch one op and wait for done. Returns in the done cycle (#1 after edge).
    // poke>0: pulse start with a=all-ones so that it is sampled at edge E(poke).
    task automatic run_op(input logic [31:0] opa, input logic opm, input int poke,
                          output int lat, output logic busy_ok);
        start = 1'b1;
        a     = opa;
        mode  = opm;
        @(posedge clk);
        #1;
        start   = 1'b0;
        a       = $urandom;
        mode    = ~opm;
        lat     = 0;
        busy_ok = busy;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
            if (k == poke - 1) begin
                start = 1'b1;
                a     = 32'hFFFF_FFFF;
                mode  = 1'b0;
            end
        end
        if (lat == 0) check("timeout", 32'd0, 32'd1);
    endtask

    // Step past the done cycle; result must be a single-cycle pulse.
    task automatic finish_op(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_op(input string tag, input logic [31:0] opa, input logic opm,
                         input int exp_cnt, input logic [31:0] exp_r, input logic exp_z);
        int   lat;
        logic bok;
        run_op(opa, opm, 0, lat, bok);
        check({tag, "_lat"}, lat, exp_z ? 32'd1 : exp_cnt + 1);
        check({tag, "_count"}, {26'd0, count}, exp_cnt);
        check({tag, "_r"}, r, exp_r);
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_z});
        check({tag, "_busy"}, {31'd0, bok}, 32'd1);
        finish_op(tag);
    endtask

    initial begin
        int          lat;
        logic        bok;
        logic        sawdone;
        logic [31:0] v;
        logic        m;
        int          ec;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        mode  = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_r", r, 32'd0);
        check("rst_count", {26'd0, count}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_op("t1", 32'h8000_0000, 1'b0, 0, 32'h8000_0000, 1'b0);
        do_op("t2", 32'h0000_0001, 1'b0, 31, 32'h8000_0000, 1'b0);
        do_op("t3a", 32'h0000_0100, 1'b1, 8, 32'h0000_0001, 1'b0);
        do_op("t3b", 32'h00F0_0000, 1'b0, 8, 32'hF000_0000, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_r", r, 32'hF000_0000);
        check("hold_count", {26'd0, count}, 32'd8);
        do_op("t4l", 32'h0, 1'b0, 32, 32'h0, 1'b1);
        do_op("t4r", 32'h0, 1'b1, 32, 32'h0, 1'b1);
        do_op("ctz31", 32'h8000_0000, 1'b1, 31, 32'h0000_0001, 1'b0);

        // Start while busy is ignored; back-to-back start right after done.
        run_op(32'h0000_0001, 1'b0, 5, lat, bok);
        check("t5_lat", lat, 32'd32);
        check("t5_count", {26'd0, count}, 32'd31);
        check("t5_r", r, 32'h8000_0000);
        finish_op("t5");
        do_op("t5b2b", 32'h0000_0F00, 1'b1, 8, 32'h0000_000F, 1'b0);

        // Reset mid-shift aborts with no done pulse.
        run_op(32'h0000_0001, 1'b0, 0, lat, bok);
        finish_op("pre6");
        start = 1'b1;
        a     = 32'h0000_0001;
        mode  = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_r", r, 32'd0);
        check("t6_count", {26'd0, count}, 32'd0);
        sawdone = done;
        repeat (3) begin
            @(posedge clk);
            #1;
            sawdone = sawdone | done;
        end
        check("t6_nodone", {31'd0, sawdone}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op("t6post", 32'h0001_0000, 1'b0, 15, 32'h8000_0000, 1'b0);

        // Random nonzero operands with varied leading/trailing zero runs.
        for (int i = 0; i < 1000; i++) begin
            m = i[0];
            v = $urandom;
            if (m) v = v << $urandom_range(0, 31);
            else   v = v >> $urandom_range(0, 31);
            if (v == 0) v = 32'h0000_0400;
            ec = m ? ref_ctz(v) : ref_clz(v);
            run_op(v, m, 0, lat, bok);
            check("rnd_lat", lat, ec + 1);
            check("rnd_count", {26'd0, count}, ec);
            check("rnd_r", r, m ? (v >> ec) : (v << ec));
            check("rnd_norm", {31'd0, m ? r[0] : r[31]}, 32'd1);
            check("rnd_zero", {31'd0, zero}, 32'd0);
            finish_op("rnd");
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
